// File: rtl/muldiv_seq_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state encoding and small op-decoding helpers.
package muldiv_seq_unit_pkg;

   localparam logic [2:0] INST_MUL    = 3'b000;
   localparam logic [2:0] INST_MULH   = 3'b001;
   localparam logic [2:0] INST_MULHSU = 3'b010;
   localparam logic [2:0] INST_MULHU  = 3'b011;
   localparam logic [2:0] INST_DIV    = 3'b100;
   localparam logic [2:0] INST_DIVU   = 3'b101;
   localparam logic [2:0] INST_REM    = 3'b110;
   localparam logic [2:0] INST_REMU   = 3'b111;

   typedef enum logic [1:0] {
      MULDIV_IDLE = 2'd0,
      MULDIV_CALC = 2'd1,
      MULDIV_FIX  = 2'd2,
      MULDIV_DONE = 2'd3
   } muldiv_state_t;

   function automatic logic op_signed_a(input logic [2:0] op);
      return (op == INST_MULH) || (op == INST_MULHSU) || (op == INST_DIV) || (op == INST_REM);
   endfunction

   function automatic logic op_signed_b(input logic [2:0] op);
      return (op == INST_MULH) || (op == INST_DIV) || (op == INST_REM);
   endfunction

   function automatic logic op_is_div(input logic [2:0] op);
      return (op == INST_DIV) || (op == INST_DIVU) || (op == INST_REM) || (op == INST_REMU);
   endfunction

   function automatic logic op_is_rem(input logic [2:0] op);
      return (op == INST_REM) || (op == INST_REMU);
   endfunction

   // MUL, quotients and remainders all come from the low half of the corrected value.
   function automatic logic op_low_half(input logic [2:0] op);
      return !((op == INST_MULH) || (op == INST_MULHSU) || (op == INST_MULHU));
   endfunction

endpackage

// File: rtl/muldiv_sign_prep.sv
// Combinational sign handling: operand magnitudes, result-negate flag and special-case
// flags at start, plus the conditional two's-complement negation applied in FIX.
module muldiv_sign_prep
   import muldiv_seq_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]        op,
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   input  logic [2*XLEN-1:0] fix_in,
   input  logic              fix_neg,
   output logic [XLEN-1:0]   a_mag,
   output logic [XLEN-1:0]   b_mag,
   output logic              neg_res,
   output logic              a_zero,
   output logic              b_zero,
   output logic              b_unit,
   output logic              sgn_ovf,
   output logic [2*XLEN-1:0] fix_out
);

   logic a_neg;
   logic b_neg;

   // NOTE: every output of a combinational block is assigned on every path (defaults
   // first where branches exist); a path that skips an assignment infers a latch.
   always_comb begin
      a_neg   = op_signed_a(op) && a[XLEN-1];
      b_neg   = op_signed_b(op) && b[XLEN-1];
      a_mag   = a_neg ? -a : a;
      b_mag   = b_neg ? -b : b;
      a_zero  = (a == '0);
      b_zero  = (b == '0);
      b_unit  = (b == XLEN'(1));
      sgn_ovf = op_is_div(op) && op_signed_b(op) &&
                (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}});

      // Remainder follows the dividend; a zero divisor keeps the all-ones quotient unsigned.
      neg_res = a_neg ^ b_neg;
      if (op_is_rem(op)) begin
         neg_res = a_neg;
      end else if (op_is_div(op) && b_zero) begin
         neg_res = 1'b0;
      end
   end

   assign fix_out = fix_neg ? -fix_in : fix_in;

endmodule

// File: rtl/muldiv_seq_unit.sv
// Iterative RV32M multiply/divide unit (radix-2 shift-add / restoring divide, one bit per cycle).
// Optional: define MULDIV_EARLY_OUT_EN to skip the iterations for b==0, a==0, b==1 and signed overflow.
module muldiv_seq_unit
   import muldiv_seq_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CNT_W = $clog2(XLEN) + 1;

`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EARLY_OUT = 1'b1;
`else
   localparam bit EARLY_OUT = 1'b0;
`endif

   muldiv_state_t state, state_nx;

   logic [2:0]        op_q;
   logic              neg_q;
   logic [XLEN-1:0]   hi_q;     // product high half / partial remainder
   logic [XLEN-1:0]   lo_q;     // multiplier -> product low half / dividend -> quotient
   logic [XLEN-1:0]   m_q;      // multiplicand or divisor magnitude
   logic [CNT_W-1:0]  cnt_q;
   logic [XLEN-1:0]   result_q;

   logic [XLEN-1:0]   a_mag, b_mag;
   logic              neg_res, a_zero, b_zero, b_unit, sgn_ovf;
   logic [2*XLEN-1:0] fix_in, fix_out;
   logic [XLEN-1:0]   fix_result;

   logic [XLEN:0]     add_sum;
   logic [XLEN:0]     div_shift;
   logic [XLEN-1:0]   div_diff;
   logic              div_ge;

   logic              take_early;
   logic [XLEN-1:0]   early_hi, early_lo;

   muldiv_sign_prep #(.XLEN(XLEN)) u_sign_prep (
      .op      (op_is_idle_like() ? op : op_q),
      .a       (operand_a),
      .b       (operand_b),
      .fix_in  (fix_in),
      .fix_neg (neg_q),
      .a_mag   (a_mag),
      .b_mag   (b_mag),
      .neg_res (neg_res),
      .a_zero  (a_zero),
      .b_zero  (b_zero),
      .b_unit  (b_unit),
      .sgn_ovf (sgn_ovf),
      .fix_out (fix_out)
   );

   function automatic logic op_is_idle_like();
      return (state == MULDIV_IDLE) || (state == MULDIV_DONE);
   endfunction

   assign take_early = EARLY_OUT && (a_zero || b_zero || b_unit || sgn_ovf);

   // Final magnitudes for the early-out cases, so FIX applies the usual sign correction.
   always_comb begin
      early_hi = '0;
      early_lo = '0;
      if (op_is_div(op) && b_zero) begin
         early_hi = a_mag;
         early_lo = {XLEN{1'b1}};
      end else if (!a_zero && !b_zero && (b_unit || sgn_ovf)) begin
         early_lo = a_mag;
      end
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         MULDIV_IDLE, MULDIV_DONE: begin
            done     = (state == MULDIV_DONE);
            state_nx = MULDIV_IDLE;
            if (start) begin
               state_nx = take_early ? MULDIV_FIX : MULDIV_CALC;
            end
         end
         MULDIV_CALC: begin
            busy = 1'b1;
            if (cnt_q == CNT_W'(XLEN - 1)) begin
               state_nx = MULDIV_FIX;
            end
         end
         MULDIV_FIX: begin
            busy     = 1'b1;
            state_nx = MULDIV_DONE;
         end
         default: state_nx = MULDIV_IDLE;
      endcase
      if (kill) begin
         state_nx = MULDIV_IDLE;
      end
   end

   // NOTE: clocked blocks use non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= MULDIV_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   assign add_sum   = {1'b0, hi_q} + {1'b0, m_q & {XLEN{lo_q[0]}}};
   assign div_shift = {hi_q, lo_q[XLEN-1]};
   assign div_ge    = (div_shift >= {1'b0, m_q});
   assign div_diff  = div_shift[XLEN-1:0] - m_q;

   always_ff @(posedge clk) begin
      if (rst || kill) begin
         op_q  <= '0;
         neg_q <= 1'b0;
         hi_q  <= '0;
         lo_q  <= '0;
         m_q   <= '0;
         cnt_q <= '0;
      end else begin
         case (state)
            MULDIV_IDLE, MULDIV_DONE: begin
               if (start) begin
                  op_q  <= op;
                  neg_q <= neg_res;
                  cnt_q <= '0;
                  m_q   <= op_is_div(op) ? b_mag : a_mag;
                  if (take_early) begin
                     hi_q <= early_hi;
                     lo_q <= early_lo;
                  end else begin
                     hi_q <= '0;
                     lo_q <= op_is_div(op) ? a_mag : b_mag;
                  end
               end
            end
            MULDIV_CALC: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (op_is_div(op_q)) begin
                  hi_q <= div_ge ? div_diff : div_shift[XLEN-1:0];
                  lo_q <= {lo_q[XLEN-2:0], div_ge};
               end else begin
                  hi_q <= add_sum[XLEN:1];
                  lo_q <= {add_sum[0], lo_q[XLEN-1:1]};
               end
            end
            default: ;
         endcase
      end
   end

   assign fix_in     = op_is_div(op_q) ? {{XLEN{1'b0}}, (op_is_rem(op_q) ? hi_q : lo_q)}
                                       : {hi_q, lo_q};
   assign fix_result = op_low_half(op_q) ? fix_out[XLEN-1:0] : fix_out[2*XLEN-1:XLEN];

   // kill discards the operation but leaves the last delivered result visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
      end else if (!kill && (state == MULDIV_FIX)) begin
         result_q <= fix_result;
      end
   end

   assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Self-checking bench for muldiv_seq_unit: arithmetic/latency reference model checked every
// cycle, plus directed vectors with hand-computed results and handshake corner cases.
module tb_muldiv_seq_unit;
   import muldiv_seq_unit_pkg::*;

   localparam int XLEN = 32;
   localparam int FULL_LAT = XLEN + 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic            kill = 1'b0;
   logic [2:0]      op = '0;
   logic [XLEN-1:0] operand_a = '0;
   logic [XLEN-1:0] operand_b = '0;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   int n_chk = 0;
   int n_pass = 0;

   muldiv_seq_unit #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .kill      (kill),
      .op        (op),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .busy      (busy),
      .done      (done),
      .result    (result)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   // Architectural result of an RV32M instruction, straight from the ISA definition.
   function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      logic        ovf;
      logic [31:0] r;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      r = '0;
      case (o)
         INST_MUL:    begin p = {32'b0, a} * {32'b0, b};               r = p[31:0];  end
         INST_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b};   r = p[63:32]; end
         INST_MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b};         r = p[63:32]; end
         INST_MULHU:  begin p = {32'b0, a} * {32'b0, b};               r = p[63:32]; end
         INST_DIV:    r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
         INST_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         INST_REM:    r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
         default:     r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   // Cycles from the start cycle to the done cycle.
   function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      int lat;
      lat = FULL_LAT;
`ifdef MULDIV_EARLY_OUT_EN
      if (a == 0 || b == 0 || b == 1 ||
          ((o == INST_DIV || o == INST_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
         lat = 2;
`else
      if (o == INST_MUL && a == 32'h1 && b == 32'h1) lat = FULL_LAT;
`endif
      return lat;
   endfunction

   // Reference model: transaction-level view of the handshake, advanced once per edge.
   int          remain = 0;
   logic [31:0] pend = '0;
   logic        exp_done = 1'b0;
   logic [31:0] exp_result = '0;
   bit          mdl_live = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         remain = 0;
         exp_done = 1'b0;
         exp_result = '0;
      end else if (kill) begin
         remain = 0;
         exp_done = 1'b0;
      end else begin
         exp_done = 1'b0;
         if (remain > 0) begin
            remain--;
            if (remain == 0) begin
               exp_done = 1'b1;
               exp_result = pend;
            end
         end else if (start) begin
            pend = ref_result(op, operand_a, operand_b);
            remain = exp_lat(op, operand_a, operand_b) - 1;
         end
      end
      mdl_live = 1'b1;
   end

   always @(negedge clk) begin
      if (mdl_live) begin
         check("cycle busy", 32'(busy), 32'(remain > 0));
         check("cycle done", 32'(done), 32'(exp_done));
         check("cycle result", result, exp_result);
      end
   end

   // Called on a negedge: start is high for exactly one cycle.
   task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o;
      operand_a = a;
      operand_b = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int from, output int lat);
      lat = from;
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (!done) begin
         n_chk++;
         $display("FAIL done timeout: got no done within %0d cycles, expected done", lat);
      end
   endtask

   task automatic directed(input string name, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, output int lat);
      @(negedge clk);
      launch(o, a, b);
      wait_done(1, lat);
      check({name, " result"}, result, exp);
      check({name, " latency"}, 32'(lat), 32'(exp_lat(o, a, b)));
   endtask

   initial begin
      int lat;
      int n_done;

      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset busy", 32'(busy), 32'h0);
      check("reset done", 32'(done), 32'h0);
      check("reset result", result, 32'h0);

      directed("mul 7*-3", INST_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, lat);
      check("mul 7*-3 done cycle", 32'(lat), 32'd34);
      directed("mulh min*min", INST_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, lat);
      directed("mulhu max*max", INST_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, lat);
      directed("mulhsu -1*2", INST_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, lat);
      directed("mulh 5*-1", INST_MULH, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
      directed("mulhu 2^31*2", INST_MULHU, 32'h8000_0000, 32'd2, 32'h0000_0001, lat);
      directed("mul 2^16*2^16", INST_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, lat);
      directed("div -7/2", INST_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, lat);
      directed("rem -7/2", INST_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, lat);
      directed("div 7/-2", INST_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, lat);
      directed("rem 7/-2", INST_REM, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, lat);
      directed("divu 100/7", INST_DIVU, 32'd100, 32'd7, 32'd14, lat);
      directed("remu 100/7", INST_REMU, 32'd100, 32'd7, 32'd2, lat);
      directed("divu 5/0", INST_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, lat);
      directed("rem 5/0", INST_REM, 32'd5, 32'd0, 32'd5, lat);
      directed("div -7/0", INST_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, lat);
      directed("rem -7/0", INST_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, lat);
      directed("div ovf", INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, lat);
      directed("rem ovf", INST_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, lat);
      directed("divu max/1", INST_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, lat);
      directed("remu 0/3", INST_REMU, 32'd0, 32'd3, 32'd0, lat);
      directed("divu 9/0 early", INST_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, lat);
`ifdef MULDIV_EARLY_OUT_EN
      check("divu 9/0 done cycle", 32'(lat), 32'd2);
`else
      check("divu 9/0 done cycle", 32'(lat), 32'd34);
`endif

      // A start while busy is ignored.
      @(negedge clk);
      launch(INST_DIVU, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      op = INST_MUL; operand_a = 32'd3; operand_b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(11, lat);
      check("ignored start result", result, 32'd14);
      check("ignored start done cycle", 32'(lat), 32'd34);

      // Back-to-back: start presented during the DONE cycle.
      directed("mul 6*7", INST_MUL, 32'd6, 32'd7, 32'd42, lat);
      launch(INST_REMU, 32'd100, 32'd7);
      wait_done(1, lat);
      check("back-to-back result", result, 32'd2);
      check("back-to-back done cycle", 32'(lat), 32'd34);

      // kill mid-operation, then kill together with start from idle.
      @(negedge clk);
      launch(INST_DIV, 32'hFFFF_FFF9, 32'd2);
      repeat (4) @(negedge clk);
      kill = 1'b1; start = 1'b1;
      @(negedge clk);
      kill = 1'b0; start = 1'b0;
      check("kill busy", 32'(busy), 32'h0);
      kill = 1'b1; start = 1'b1; op = INST_DIVU; operand_a = 32'd50; operand_b = 32'd5;
      @(negedge clk);
      kill = 1'b0; start = 1'b0;
      check("kill beats start busy", 32'(busy), 32'h0);
      n_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("kill no done", 32'(n_done), 32'd0);
      check("kill result kept", result, 32'd2);

      // Synchronous reset mid-divide.
      launch(INST_DIVU, 32'hFFFF_FFFF, 32'd3);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst busy", 32'(busy), 32'h0);
      check("rst done", 32'(done), 32'h0);
      check("rst result", result, 32'h0);

      // Mixed operands; the per-cycle model comparison covers these.
      for (int i = 0; i < 16; i++) begin
         logic [31:0] ra, rb;
         logic [2:0]  ro;
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         @(negedge clk);
         launch(ro, ra, rb);
         wait_done(1, lat);
      end
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
